// File: rtl/can_attack_detector.sv
// Decision-tree classifier for CAN-bus intrusion detection: walks a preloaded tree from node 0,
// comparing one stored feature per node against its threshold until a leaf or the depth limit.
module can_attack_detector #(
    parameter int    TREE_DEPTH   = 512,
    parameter int    MAX_DEPTH    = 20,
    parameter string TREE_FILE    = "tree.mem",
    parameter string FEATURE_FILE = "features.mem"
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       done,
    output logic       is_attack,
    output logic [1:0] attack_class,
    output logic [8:0] final_node,
    output logic [4:0] tree_depth
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StRead   = 3'd2,
        StEval   = 3'd3,
        StFinish = 3'd4
    } state_e;

    localparam logic [4:0] MaxDepth = 5'(MAX_DEPTH);

    logic [63:0] tree_mem [TREE_DEPTH];
    logic [31:0] feat_mem [32];

    state_e      state_q;
    logic [8:0]  node_q;
    logic [4:0]  depth_q;
    logic [1:0]  class_q;
    logic [57:0] word_q;   // node word without the reserved low bits
    logic [31:0] feat_q;

    logic        w_leaf;
    logic [1:0]  w_class;
    logic [4:0]  w_fidx;
    logic [31:0] w_thresh;
    logic [8:0]  w_left;
    logic [8:0]  w_right;

    assign w_leaf   = word_q[57];
    assign w_class  = word_q[56:55];
    assign w_fidx   = word_q[54:50];
    assign w_thresh = word_q[49:18];
    assign w_left   = word_q[17:9];
    assign w_right  = word_q[8:0];

    // Free-running synchronous reads: the node word lands after FETCH, its feature after READ.
    always_ff @(posedge clk) begin
        word_q <= tree_mem[node_q][63:6];
        feat_q <= feat_mem[w_fidx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            node_q       <= '0;
            depth_q      <= '0;
            class_q      <= '0;
            done         <= 1'b0;
            is_attack    <= 1'b0;
            attack_class <= '0;
            final_node   <= '0;
            tree_depth   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        node_q  <= '0;
                        depth_q <= '0;
                        done    <= 1'b0;
                        state_q <= StFetch;
                    end
                end
                StFetch: state_q <= StRead;
                StRead:  state_q <= StEval;
                StEval: begin
                    if (w_leaf) begin
                        class_q <= w_class;
                        state_q <= StFinish;
                    end else if (depth_q == MaxDepth) begin
                        class_q <= 2'd3;
                        state_q <= StFinish;
                    end else begin
                        depth_q <= depth_q + 5'd1;
                        node_q  <= (feat_q <= w_thresh) ? w_left : w_right;
                        state_q <= StFetch;
                    end
                end
                StFinish: begin
                    done         <= 1'b1;
                    attack_class <= class_q;
                    is_attack    <= (class_q != 2'd0);
                    final_node   <= node_q;
                    tree_depth   <= depth_q;
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_can_attack_detector.sv
// Directed bench for can_attack_detector; memories are preloaded hierarchically, no hex files.
module tb_can_attack_detector;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       done;
    logic       is_attack;
    logic [1:0] attack_class;
    logic [8:0] final_node;
    logic [4:0] tree_depth;

    int total = 0;
    int bad   = 0;

    can_attack_detector #(
        .TREE_DEPTH  (512),
        .MAX_DEPTH   (20),
        .TREE_FILE   (""),
        .FEATURE_FILE("")
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .done        (done),
        .is_attack   (is_attack),
        .attack_class(attack_class),
        .final_node  (final_node),
        .tree_depth  (tree_depth)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic leaf, input logic [1:0] cls,
                                       input logic [4:0] fidx, input logic [31:0] thr,
                                       input logic [8:0] l, input logic [8:0] r);
        return {leaf, cls, fidx, thr, l, r, 6'd0};
    endfunction

    task automatic clear_mems();
        for (int i = 0; i < 512; i++) dut.tree_mem[i] = mk(1'b1, 2'd0, 5'd0, 32'd0, 9'd0, 9'd0);
        for (int i = 0; i < 32; i++) dut.feat_mem[i] = 32'd0;
    endtask

    // Two-level tree: node0 compares feature0 with 100, node1 normal leaf, node2 class-2 leaf.
    task automatic load_simple(input logic [31:0] f0);
        clear_mems();
        dut.tree_mem[0] = mk(1'b0, 2'd0, 5'd0, 32'd100, 9'd1, 9'd2);
        dut.tree_mem[1] = mk(1'b1, 2'd0, 5'd0, 32'd0, 9'd0, 9'd0);
        dut.tree_mem[2] = mk(1'b1, 2'd2, 5'd0, 32'd0, 9'd0, 9'd0);
        dut.feat_mem[0] = f0;
    endtask

    // Pulse start, count cycles to done; optionally re-pulse start at cycle repulse.
    task automatic run(input int repulse, output int lat);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_drop", 32'(done), 32'd0);
        lat = 0;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
            start = (lat == repulse);
        end
        start = 1'b0;
        if (!done) check("timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_result(input string tag, input int lat, input int elat,
                                 input logic att, input logic [1:0] cls,
                                 input logic [8:0] node, input logic [4:0] depth);
        check({tag, "_lat"}, 32'(lat), 32'(elat));
        check({tag, "_att"}, 32'(is_attack), 32'(att));
        check({tag, "_cls"}, 32'(attack_class), 32'(cls));
        check({tag, "_node"}, 32'(final_node), 32'(node));
        check({tag, "_depth"}, 32'(tree_depth), 32'(depth));
    endtask

    int lat;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        clear_mems();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_done", 32'(done), 32'd0);
        check("rst_att", 32'(is_attack), 32'd0);
        check("rst_cls", 32'(attack_class), 32'd0);
        check("rst_node", 32'(final_node), 32'd0);
        check("rst_depth", 32'(tree_depth), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'd0);
        repeat (5) @(negedge clk);
        check("idle_nodone", 32'(done), 32'd0);

        load_simple(32'd50);
        run(0, lat);
        expect_result("normal", lat, 7, 1'b0, 2'd0, 9'd1, 5'd1);

        load_simple(32'd101);
        run(0, lat);
        expect_result("attack", lat, 7, 1'b1, 2'd2, 9'd2, 5'd1);

        load_simple(32'd100);
        run(0, lat);
        expect_result("equal", lat, 7, 1'b0, 2'd0, 9'd1, 5'd1);

        clear_mems();
        dut.tree_mem[0] = mk(1'b1, 2'd1, 5'd0, 32'd0, 9'd0, 9'd0);
        run(0, lat);
        expect_result("root", lat, 4, 1'b1, 2'd1, 9'd0, 5'd0);

        // 25-node internal chain on feature 5; abort lands on node 20 after 20 evaluations.
        clear_mems();
        for (int i = 0; i < 25; i++)
            dut.tree_mem[i] = mk(1'b0, 2'd0, 5'd5, 32'd7, 9'(i + 1), 9'(i + 1));
        dut.feat_mem[5] = 32'd9;
        run(0, lat);
        expect_result("chain", lat, 64, 1'b1, 2'd3, 9'd20, 5'd20);

        load_simple(32'd101);
        run(3, lat);
        expect_result("repulse", lat, 7, 1'b1, 2'd2, 9'd2, 5'd1);
        @(negedge clk);
        run(0, lat);
        expect_result("restart", lat, 7, 1'b1, 2'd2, 9'd2, 5'd1);

        // start together with rst: reset wins, FSM stays idle.
        start = 1'b1;
        rst   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        check("rststart_state", 32'(dut.state_q), 32'd0);
        check("rststart_node", 32'(final_node), 32'd0);

        // Reset mid-traversal once the FSM reaches EVAL.
        load_simple(32'd101);
        run(0, lat);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && dut.state_q != 3'd3; i++) @(negedge clk);
        check("mid_in_eval", 32'(dut.state_q), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_state", 32'(dut.state_q), 32'd0);
        check("mid_done", 32'(done), 32'd0);
        check("mid_att", 32'(is_attack), 32'd0);
        check("mid_node", 32'(final_node), 32'd0);
        check("mid_depth", 32'(tree_depth), 32'd0);
        @(negedge clk);
        run(0, lat);
        expect_result("after_rst", lat, 7, 1'b1, 2'd2, 9'd2, 5'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
